// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 2;

   localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_ISSUE = 2'd0,
      FETCH_WAIT  = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] pc4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory bus: valid/ready request channel, valid-only in-order response channel.
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [INSTR_W-1:0] imem_req_addr;
   logic               imem_resp_valid;
   logic [INSTR_W-1:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of {instruction, pc4}; the head entry is driven straight from flops.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   logic [CNT_W-1:0] count_q, count_d;
   fetch_entry_t     head_q, head_d;
   fetch_entry_t     tail_q, tail_d;
   logic             pop_ok;

   assign pop_ok = pop && (count_q != '0);

   // Flush wins over push; an empty-to-empty pop leaves the head untouched.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         count_d = '0;
      end else if (push && !pop_ok) begin
         if (count_q == CNT_W'(0)) begin
            head_d  = push_entry;
            count_d = CNT_W'(1);
         end else if (count_q == CNT_W'(1)) begin
            tail_d  = push_entry;
            count_d = CNT_W'(2);
         end
      end else if (!push && pop_ok) begin
         if (count_q == CNT_W'(2)) begin
            head_d = tail_q;
         end
         count_d = count_q - CNT_W'(1);
      end else if (push && pop_ok) begin
         if (count_q == CNT_W'(1)) begin
            head_d = push_entry;
         end else begin
            head_d = tail_q;
            tail_d = push_entry;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign count = count_q;
   assign head  = head_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: owns the PC, keeps one memory request in flight and feeds decode through a 2-entry buffer.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned        BUF_DEPTH = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                redirect_valid,
   input  logic [INSTR_W-1:0]  redirect_addr,
   fetch_sequencer_if.master   imem,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instruction,
   output logic [INSTR_W-1:0]  pc4
);

   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] req_pc_q, req_pc_d;
   logic [INSTR_W-1:0] redirect_pc;
   logic               req_valid;
   logic               push;
   logic               pop;
   logic [CNT_W-1:0]   count;
   fetch_entry_t       push_entry;
   fetch_entry_t       head;

   assign redirect_pc = {redirect_addr[INSTR_W-1:2], 2'b00};

   // A request only issues when the buffer has room for its response.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      req_valid = 1'b0;
      push      = 1'b0;
      case (state_q)
         FETCH_ISSUE: begin
            req_valid = (32'(count) < BUF_DEPTH) && !reset;
            if (req_valid && imem.imem_req_ready) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + INSTR_W'(4);
               state_d  = redirect_valid ? FETCH_DRAIN : FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (imem.imem_resp_valid) begin
               push    = !redirect_valid;
               state_d = FETCH_ISSUE;
            end else if (redirect_valid) begin
               state_d = FETCH_DRAIN;
            end
         end
         FETCH_DRAIN: begin
            if (imem.imem_resp_valid) begin
               state_d = FETCH_ISSUE;
            end
         end
         default: state_d = FETCH_ISSUE;
      endcase
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= FETCH_ISSUE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   assign push_entry = '{instr: imem.imem_resp_data, pc4: req_pc_q + INSTR_W'(4)};
   assign pop        = instr_valid && instr_ready;

   fetch_buffer u_buffer (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head       (head)
   );

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_q;
   assign instr_valid         = (count != '0);
   assign instruction         = head.instr;
   assign pc4                 = head.pc4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level reference model with a randomized memory and decode.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] pc4;

   fetch_sequencer_if imem_bus ();

   fetch_sequencer #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem           (imem_bus),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .pc4            (pc4)
   );

   always #5 clock = ~clock;

   // Reference model: architectural PC, expected decode queue, one memory transaction in flight.
   logic [31:0]  pc_m;
   fetch_entry_t q_m[$];
   bit           outst;
   bit           stale;
   logic [31:0]  out_addr;
   logic [31:0]  out_data;
   int           lat_cnt;
   int           lat_min;
   int           lat_max;
   bit           after_rst;
   int           cyc;
   logic [31:0]  acc_log[$];
   int           acc_cyc[$];
   logic [31:0]  pop_log[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input bit rst, input bit redir, input logic [31:0] raddr,
                       input bit rdy, input bit iready, input bit orphan);
      bit          exp_rv, resp, accept, pop_m;
      logic [31:0] pc_old;
      @(negedge clock);
      resp = (outst && lat_cnt == 0) || orphan;
      reset                   = rst;
      redirect_valid          = redir;
      redirect_addr           = raddr;
      imem_bus.imem_req_ready = rdy;
      imem_bus.imem_resp_valid = resp;
      imem_bus.imem_resp_data = resp ? (orphan ? 32'hDEAD_BEEF : out_data) : $urandom;
      instr_ready             = iready;
      #1;
      exp_rv = !rst && !outst && (q_m.size() < 2);
      check("req_valid", 32'(imem_bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("req_addr", imem_bus.imem_req_addr, pc_m);
      check("instr_valid", 32'(instr_valid), 32'(q_m.size() != 0));
      if (q_m.size() != 0) begin
         check("instruction", instruction, q_m[0].instr);
         check("pc4", pc4, q_m[0].pc4);
      end
      if (after_rst) begin
         check("rst_instruction", instruction, 32'h0);
         check("rst_pc4", pc4, 32'h0);
      end
      after_rst = 1'b0;
      cyc++;
      if (rst) begin
         pc_m      = RST_PC;
         q_m.delete();
         outst     = 1'b0;
         after_rst = 1'b1;
      end else begin
         accept = exp_rv && rdy;
         pop_m  = (q_m.size() != 0) && iready;
         if (pop_m) begin
            pop_log.push_back(q_m[0].pc4);
            void'(q_m.pop_front());
         end
         if (resp && !orphan) begin
            if (!stale && !redir) q_m.push_back('{instr: out_data, pc4: out_addr + 32'd4});
            outst = 1'b0;
         end else if (outst) begin
            lat_cnt--;
            if (redir) stale = 1'b1;
         end
         if (redir) q_m.delete();
         pc_old = pc_m;
         if (redir) pc_m = {raddr[31:2], 2'b00};
         if (accept) begin
            outst    = 1'b1;
            out_addr = pc_old;
            out_data = $urandom;
            stale    = redir;
            lat_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
            acc_log.push_back(pc_old);
            acc_cyc.push_back(cyc);
            if (!redir) pc_m = pc_old + 32'd4;
         end
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_logs();
      acc_log.delete();
      acc_cyc.delete();
      pop_log.delete();
   endtask

   task automatic wait_outst(input int max_cycles);
      int n = 0;
      while (!outst && n < max_cycles) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
         n++;
      end
      check("wait_outstanding", 32'(outst), 32'd1);
   endtask

   task automatic chk_acc(input string tag, input int idx, input logic [31:0] exp);
      if (idx < acc_log.size()) check(tag, acc_log[idx], exp);
      else check({tag, "_missing"}, 32'(acc_log.size()), 32'(idx + 1));
   endtask

   task automatic chk_pop(input string tag, input int idx, input logic [31:0] exp);
      if (idx < pop_log.size()) check(tag, pop_log[idx], exp);
      else check({tag, "_missing"}, 32'(pop_log.size()), 32'(idx + 1));
   endtask

   initial begin
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr = '0;
      instr_ready = 1'b0;
      imem_bus.imem_req_ready = 1'b0;
      imem_bus.imem_resp_valid = 1'b0;
      imem_bus.imem_resp_data = '0;
      pc_m = RST_PC; outst = 1'b0; stale = 1'b0; lat_cnt = 0;
      out_addr = '0; out_data = '0; after_rst = 1'b0; cyc = 0;
      lat_min = 1; lat_max = 1;

      // Streaming with a single-cycle memory
      do_reset();
      clear_logs();
      repeat (7) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk_acc("t1_addr0", 0, 32'h0);
      chk_acc("t1_addr1", 1, 32'h4);
      chk_acc("t1_addr2", 2, 32'h8);
      if (acc_cyc.size() >= 2) check("t1_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk_pop("t1_pc4_0", 0, 32'h4);
      chk_pop("t1_pc4_1", 1, 32'h8);
      chk_pop("t1_pc4_2", 2, 32'hC);

      // Decode stall fills the buffer and blocks requests
      do_reset();
      repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("t2_blocked", 32'(imem_bus.imem_req_valid), 32'd0);
      clear_logs();
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk_pop("t2_pc4_0", 0, 32'h4);
      chk_pop("t2_pc4_1", 1, 32'h8);
      chk_acc("t2_next_addr", 0, 32'h8);

      // Redirect while waiting on a slow response
      do_reset();
      lat_min = 3; lat_max = 3;
      wait_outst(10);
      clear_logs();
      step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      lat_min = 1; lat_max = 1;
      repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk_acc("t3_addr", 0, 32'h40);
      chk_pop("t3_pc4", 0, 32'h44);

      // Redirect coinciding with the response
      do_reset();
      wait_outst(10);
      clear_logs();
      step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk_acc("t4_addr", 0, 32'h80);
      chk_pop("t4_pc4", 0, 32'h84);

      // Redirect to an unaligned top-of-memory address wraps the PC
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      clear_logs();
      step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk_acc("t5_addr0", 0, 32'hFFFF_FFFC);
      chk_acc("t5_addr1", 1, 32'h0000_0000);
      chk_pop("t5_pc4_0", 0, 32'h0000_0000);
      chk_pop("t5_pc4_1", 1, 32'h0000_0004);

      // Reset during WAIT, then a late response right after reset
      do_reset();
      lat_min = 3; lat_max = 3;
      wait_outst(10);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      lat_min = 1; lat_max = 1;
      clear_logs();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk_acc("t6_addr", 0, RST_PC);
      chk_pop("t6_pc4", 0, RST_PC + 32'd4);

      // Randomized traffic
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         bit          r_rst, r_redir;
         logic [31:0] r_addr;
         r_rst   = ($urandom_range(199, 0) == 0);
         r_redir = ($urandom_range(15, 0) == 0);
         r_addr  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                               : $urandom;
         step(r_rst, r_redir, r_addr, ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 6), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
